// File: rtl/fp16_argmax_stream_if.sv
// Stream/result bundle for fp16_argmax_stream.
// master: upstream producer of beats and consumer of results.
// slave : the arg-max/arg-min reduction block itself.
interface fp16_argmax_stream_if #(
  parameter int IDX_W = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [15:0]      s_data;
  logic             s_last;
  logic             find_min;
  logic             m_valid;
  logic             m_ready;
  logic [15:0]      m_value;
  logic [IDX_W-1:0] m_index;
  logic             m_nan;
  logic             m_overflow;

  modport master (
    output s_valid, s_data, s_last, find_min, m_ready,
    input  s_ready, m_valid, m_value, m_index, m_nan, m_overflow
  );

  modport slave (
    input  s_valid, s_data, s_last, find_min, m_ready,
    output s_ready, m_valid, m_value, m_index, m_nan, m_overflow
  );
endinterface

// File: rtl/fp16_argmax_stream.sv
// fp16_argmax_stream: streaming arg-max / arg-min over packets of fp16 beats.
// One result per packet (best value, 0-based beat index, NaN and index-overflow
// flags), registered and presented one cycle after the last beat.
// Build option: define FP16_ARGMAX_NAN_PROP_EN for NaN-propagate behaviour
// (first NaN wins, reported as canonical 16'h7E00). Default is NaN-skip.

// fp16 comparator: a versus b, exactly one flag set.
module fp16_cmp (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        lt,
  output logic        eq,
  output logic        gt,
  output logic        unord
);
  logic a_nan_s;
  logic b_nan_s;

  assign a_nan_s = (a[14:10] == 5'h1F) && (a[9:0] != 10'h000);
  assign b_nan_s = (b[14:10] == 5'h1F) && (b[9:0] != 10'h000);

  // Sign-magnitude ordering; +0 and -0 compare equal, NaN is unordered.
  always_comb begin
    lt    = 1'b0;
    eq    = 1'b0;
    gt    = 1'b0;
    unord = 1'b0;
    if (a_nan_s || b_nan_s) begin
      unord = 1'b1;
    end else if (((a[14:0] == 15'h0000) && (b[14:0] == 15'h0000)) || (a == b)) begin
      eq = 1'b1;
    end else if (a[15] != b[15]) begin
      gt = ~a[15];
      lt = a[15];
    end else if (a[15] == 1'b0) begin
      gt = (a[14:0] > b[14:0]);
      lt = (a[14:0] < b[14:0]);
    end else begin
      gt = (a[14:0] < b[14:0]);
      lt = (a[14:0] > b[14:0]);
    end
  end
endmodule

module fp16_argmax_stream #(
  parameter int IDX_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  fp16_argmax_stream_if.slave bus
);
  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_ACC   = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(1'b0);
  localparam logic [IDX_W-1:0] CNT_ONE   = IDX_W'(1'b1);
  localparam logic [15:0]      CANON_NAN = 16'h7E00;

  function automatic logic is_nan(input logic [15:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] != 10'h000);
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [15:0]      best_r;
  logic [IDX_W-1:0] best_idx_r;
  logic [IDX_W-1:0] cnt_r;
  logic             mode_r;
  logic             best_nan_r;
  logic             ovf_r;

  logic [15:0]      best_nxt_s;
  logic [IDX_W-1:0] idx_nxt_s;
  logic [IDX_W-1:0] cnt_nxt_s;
  logic             mode_nxt_s;
  logic             nan_nxt_s;
  logic             ovf_nxt_s;

  logic             m_valid_r;
  logic [15:0]      m_value_r;
  logic [IDX_W-1:0] m_index_r;
  logic             m_nan_r;
  logic             m_ovf_r;

  logic             s_ready_s;
  logic             accept_s;
  logic             in_nan_s;
  logic             better_s;
  logic             cmp_lt_s;
  logic             cmp_eq_s;
  logic             cmp_gt_s;
  logic             cmp_unord_s;

  assign s_ready_s = (state_r != ST_OUT) & ~rst;
  assign accept_s  = bus.s_valid & s_ready_s;
  assign in_nan_s  = is_nan(bus.s_data);

  fp16_cmp u_cmp (
    .a     (bus.s_data),
    .b     (best_r),
    .lt    (cmp_lt_s),
    .eq    (cmp_eq_s),
    .gt    (cmp_gt_s),
    .unord (cmp_unord_s)
  );

  // Strictly better beat in the packet's mode; ties keep the earliest index.
  always_comb begin
    better_s = 1'b0;
    if (mode_r) begin
      better_s = cmp_lt_s & ~cmp_eq_s;
    end else begin
      better_s = cmp_gt_s & ~cmp_eq_s;
    end
  end

  // Next running-best state for the beat currently on the input.
  always_comb begin
    best_nxt_s = best_r;
    idx_nxt_s  = best_idx_r;
    cnt_nxt_s  = cnt_r;
    mode_nxt_s = mode_r;
    nan_nxt_s  = best_nan_r;
    ovf_nxt_s  = ovf_r;
    if (state_r == ST_FIRST) begin
      idx_nxt_s  = IDX_ZERO;
      cnt_nxt_s  = CNT_ONE;
      mode_nxt_s = bus.find_min;
      nan_nxt_s  = in_nan_s;
      ovf_nxt_s  = 1'b0;
`ifdef FP16_ARGMAX_NAN_PROP_EN
      if (in_nan_s) begin
        best_nxt_s = CANON_NAN;
      end else begin
        best_nxt_s = bus.s_data;
      end
`else
      best_nxt_s = bus.s_data;
`endif
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
      // cnt is only zero inside a packet after it has wrapped past 2**IDX_W-1
      ovf_nxt_s = ovf_r | (cnt_r == IDX_ZERO);
`ifdef FP16_ARGMAX_NAN_PROP_EN
      if (best_nan_r) begin
        // a NaN already won; later beats are only counted
        best_nxt_s = best_r;
      end else if (cmp_unord_s) begin
        // best is never NaN here, so unordered means this beat is NaN
        best_nxt_s = CANON_NAN;
        idx_nxt_s  = cnt_r;
        nan_nxt_s  = 1'b1;
      end else if (better_s) begin
        best_nxt_s = bus.s_data;
        idx_nxt_s  = cnt_r;
      end else begin
        best_nxt_s = best_r;
      end
`else
      if (cmp_unord_s) begin
        if (in_nan_s) begin
          // NaN beats never displace anything
          best_nxt_s = best_r;
        end else begin
          // best is a leading NaN: first real number takes over
          best_nxt_s = bus.s_data;
          idx_nxt_s  = cnt_r;
          nan_nxt_s  = 1'b0;
        end
      end else if (better_s) begin
        best_nxt_s = bus.s_data;
        idx_nxt_s  = cnt_r;
      end else begin
        best_nxt_s = best_r;
      end
`endif
    end
  end

  // Packet FSM: FIRST -> ACC -> OUT -> FIRST.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FIRST: begin
        if (accept_s) begin
          state_nxt_s = bus.s_last ? ST_OUT : ST_ACC;
        end else begin
          state_nxt_s = ST_FIRST;
        end
      end
      ST_ACC: begin
        if (accept_s && bus.s_last) begin
          state_nxt_s = ST_OUT;
        end else begin
          state_nxt_s = ST_ACC;
        end
      end
      ST_OUT: begin
        if (bus.m_ready) begin
          state_nxt_s = ST_FIRST;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: state_nxt_s = ST_FIRST;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_FIRST;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Running best / counter registers, updated on every accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_r     <= 16'h0000;
      best_idx_r <= IDX_ZERO;
      cnt_r      <= IDX_ZERO;
      mode_r     <= 1'b0;
      best_nan_r <= 1'b0;
      ovf_r      <= 1'b0;
    end else if (accept_s) begin
      best_r     <= best_nxt_s;
      best_idx_r <= idx_nxt_s;
      cnt_r      <= cnt_nxt_s;
      mode_r     <= mode_nxt_s;
      best_nan_r <= nan_nxt_s;
      ovf_r      <= ovf_nxt_s;
    end else if ((state_r == ST_OUT) && bus.m_ready) begin
      best_nan_r <= 1'b0;
      ovf_r      <= 1'b0;
    end
  end

  // Result registers: loaded with the last beat folded in, held until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_r <= 1'b0;
      m_value_r <= 16'h0000;
      m_index_r <= IDX_ZERO;
      m_nan_r   <= 1'b0;
      m_ovf_r   <= 1'b0;
    end else if (accept_s && bus.s_last) begin
      m_valid_r <= 1'b1;
      m_value_r <= nan_nxt_s ? CANON_NAN : best_nxt_s;
      m_index_r <= idx_nxt_s;
      m_nan_r   <= nan_nxt_s;
      m_ovf_r   <= ovf_nxt_s;
    end else if ((state_r == ST_OUT) && bus.m_ready) begin
      m_valid_r <= 1'b0;
    end
  end

  assign bus.s_ready    = s_ready_s;
  assign bus.m_valid    = m_valid_r;
  assign bus.m_value    = m_value_r;
  assign bus.m_index    = m_index_r;
  assign bus.m_nan      = m_nan_r;
  assign bus.m_overflow = m_ovf_r;
endmodule

// File: tb/tb_fp16_argmax_stream.sv
// Directed bench for fp16_argmax_stream (IDX_W=8 instance plus an IDX_W=2
// instance for index wrap). NaN expectations follow FP16_ARGMAX_NAN_PROP_EN.
module tb_fp16_argmax_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fp16_argmax_stream_if #(.IDX_W(8)) bus ();
  fp16_argmax_stream_if #(.IDX_W(2)) bus2 ();

  fp16_argmax_stream #(.IDX_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
  fp16_argmax_stream #(.IDX_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  // Present one beat on bus, wait (bounded) for it to be taken; returns at a negedge.
  task automatic send_beat(input logic [15:0] d, input logic last, input logic fm);
    int n;
    n = 0;
    bus.s_valid  = 1'b1;
    bus.s_data   = d;
    bus.s_last   = last;
    bus.find_min = fm;
    while ((bus.s_ready !== 1'b1) && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL beat_accept: s_ready=%b required 1 within 50 cycles", bus.s_ready);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  // Take the current result (one handshake cycle).
  task automatic pop();
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [26:0] got;
    logic [20:0] got2;
    #12;
    got  = {bus.m_valid, bus.m_value, bus.m_index, bus.m_nan, bus.m_overflow};
    got2 = {bus2.m_valid, bus2.m_value, bus2.m_index, bus2.m_nan, bus2.m_overflow};
    checks++;
    if (got !== 27'h0) begin errors++; $display("FAIL reset_outputs: got %h want %h", got, 27'h0); end
    checks++;
    if (got2 !== 21'h0) begin errors++; $display("FAIL reset_outputs2: got %h want %h", got2, 21'h0); end
    checks++;
    if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", bus.s_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL post_reset_s_ready: got %b want 1", bus.s_ready); end
  endtask

  task automatic test_max();
    logic [26:0] got;
    send_beat(16'h3C00, 1'b0, 1'b0);
    send_beat(16'h4000, 1'b0, 1'b0);
    send_beat(16'hC200, 1'b0, 1'b0);
    checks++;
    if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL max_early_valid: got %b want 0", bus.m_valid); end
    send_beat(16'h4000, 1'b1, 1'b0);
    got = {bus.m_valid, bus.m_value, bus.m_index, bus.m_nan, bus.m_overflow};
    checks++;
    if (got !== {1'b1, 16'h4000, 8'd1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL max_result: got %h want %h", got, {1'b1, 16'h4000, 8'd1, 1'b0, 1'b0});
    end
    pop();
    checks++;
    if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL max_valid_clear: got %b want 0", bus.m_valid); end
  endtask

  task automatic test_min();
    logic [26:0] got;
    send_beat(16'h3C00, 1'b0, 1'b1);
    send_beat(16'h4000, 1'b0, 1'b1);
    send_beat(16'hC200, 1'b0, 1'b1);
    send_beat(16'h4000, 1'b1, 1'b1);
    got = {bus.m_valid, bus.m_value, bus.m_index, bus.m_nan, bus.m_overflow};
    checks++;
    if (got !== {1'b1, 16'hC200, 8'd2, 1'b0, 1'b0}) begin
      errors++; $display("FAIL min_result: got %h want %h", got, {1'b1, 16'hC200, 8'd2, 1'b0, 1'b0});
    end
    pop();
    send_beat(16'h3800, 1'b1, 1'b1);
    got = {bus.m_valid, bus.m_value, bus.m_index, bus.m_nan, bus.m_overflow};
    checks++;
    if (got !== {1'b1, 16'h3800, 8'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL min_single: got %h want %h", got, {1'b1, 16'h3800, 8'd0, 1'b0, 1'b0});
    end
    pop();
    // mode comes from the first beat only: later find_min=0 is ignored
    send_beat(16'h3C00, 1'b0, 1'b1);
    send_beat(16'h4000, 1'b0, 1'b0);
    send_beat(16'h3800, 1'b1, 1'b0);
    got = {bus.m_valid, bus.m_value, bus.m_index, bus.m_nan, bus.m_overflow};
    checks++;
    if (got !== {1'b1, 16'h3800, 8'd2, 1'b0, 1'b0}) begin
      errors++; $display("FAIL min_mode_held: got %h want %h", got, {1'b1, 16'h3800, 8'd2, 1'b0, 1'b0});
    end
    pop();
  endtask

  task automatic test_ties();
    logic [26:0] got;
    send_beat(16'h8000, 1'b0, 1'b0);
    send_beat(16'h0000, 1'b1, 1'b0);
    got = {bus.m_valid, bus.m_value, bus.m_index, bus.m_nan, bus.m_overflow};
    checks++;
    if (got !== {1'b1, 16'h8000, 8'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL tie_zeros_max: got %h want %h", got, {1'b1, 16'h8000, 8'd0, 1'b0, 1'b0});
    end
    pop();
    send_beat(16'h0000, 1'b0, 1'b1);
    send_beat(16'h8000, 1'b1, 1'b1);
    got = {bus.m_valid, bus.m_value, bus.m_index, bus.m_nan, bus.m_overflow};
    checks++;
    if (got !== {1'b1, 16'h0000, 8'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL tie_zeros_min: got %h want %h", got, {1'b1, 16'h0000, 8'd0, 1'b0, 1'b0});
    end
    pop();
    send_beat(16'h7C00, 1'b0, 1'b0);
    send_beat(16'h7C00, 1'b1, 1'b0);
    got = {bus.m_valid, bus.m_value, bus.m_index, bus.m_nan, bus.m_overflow};
    checks++;
    if (got !== {1'b1, 16'h7C00, 8'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL tie_inf: got %h want %h", got, {1'b1, 16'h7C00, 8'd0, 1'b0, 1'b0});
    end
    pop();
  endtask

  task automatic test_nan();
    logic [26:0] got;
    logic [26:0] exp;
    send_beat(16'h3C00, 1'b0, 1'b0);
    send_beat(16'h7E01, 1'b0, 1'b0);
    send_beat(16'h3800, 1'b1, 1'b0);
`ifdef FP16_ARGMAX_NAN_PROP_EN
    exp = {1'b1, 16'h7E00, 8'd1, 1'b1, 1'b0};
`else
    exp = {1'b1, 16'h3C00, 8'd0, 1'b0, 1'b0};
`endif
    got = {bus.m_valid, bus.m_value, bus.m_index, bus.m_nan, bus.m_overflow};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL nan_mid: got %h want %h", got, exp); end
    pop();
    send_beat(16'h7E01, 1'b0, 1'b0);
    send_beat(16'hFE00, 1'b1, 1'b0);
    exp = {1'b1, 16'h7E00, 8'd0, 1'b1, 1'b0};
    got = {bus.m_valid, bus.m_value, bus.m_index, bus.m_nan, bus.m_overflow};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL nan_all: got %h want %h", got, exp); end
    pop();
    send_beat(16'h7E01, 1'b0, 1'b0);
    send_beat(16'h3800, 1'b0, 1'b0);
    send_beat(16'h4000, 1'b1, 1'b0);
`ifdef FP16_ARGMAX_NAN_PROP_EN
    exp = {1'b1, 16'h7E00, 8'd0, 1'b1, 1'b0};
`else
    exp = {1'b1, 16'h4000, 8'd2, 1'b0, 1'b0};
`endif
    got = {bus.m_valid, bus.m_value, bus.m_index, bus.m_nan, bus.m_overflow};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL nan_leading: got %h want %h", got, exp); end
    pop();
  endtask

  task automatic test_back_to_back();
    logic [26:0] got;
    logic [26:0] exp;
    send_beat(16'h4400, 1'b0, 1'b0);
    send_beat(16'h4200, 1'b1, 1'b0);
    exp = {1'b1, 16'h4400, 8'd0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      got = {bus.m_valid, bus.m_value, bus.m_index, bus.m_nan, bus.m_overflow};
      checks++;
      if ((got !== exp) || (bus.s_ready !== 1'b0)) begin
        errors++;
        $display("FAIL hold_cycle%0d: got %h s_ready %b want %h s_ready 0", i, got, bus.s_ready, exp);
      end
      @(negedge clk);
    end
    // next beat waits while the result is handed over
    bus.s_valid  = 1'b1;
    bus.s_data   = 16'h3000;
    bus.s_last   = 1'b1;
    bus.find_min = 1'b0;
    bus.m_ready  = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    checks++;
    if ((bus.m_valid !== 1'b0) || (bus.s_ready !== 1'b1)) begin
      errors++;
      $display("FAIL bubble: m_valid %b s_ready %b want m_valid 0 s_ready 1", bus.m_valid, bus.s_ready);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    got = {bus.m_valid, bus.m_value, bus.m_index, bus.m_nan, bus.m_overflow};
    checks++;
    if (got !== {1'b1, 16'h3000, 8'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL after_bubble: got %h want %h", got, {1'b1, 16'h3000, 8'd0, 1'b0, 1'b0});
    end
    pop();
  endtask

  task automatic test_overflow();
    logic [15:0] d5 [5];
    logic [15:0] d4 [4];
    logic [20:0] got;
    d5 = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h4000};
    d4 = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h4000};
    for (int i = 0; i < 5; i++) begin
      bus2.s_valid  = 1'b1;
      bus2.s_data   = d5[i];
      bus2.s_last   = (i == 4);
      bus2.find_min = 1'b0;
      checks++;
      if (bus2.s_ready !== 1'b1) begin errors++; $display("FAIL ovf_ready%0d: got %b want 1", i, bus2.s_ready); end
      @(negedge clk);
    end
    bus2.s_valid = 1'b0;
    got = {bus2.m_valid, bus2.m_value, bus2.m_index, bus2.m_nan, bus2.m_overflow};
    checks++;
    if (got !== {1'b1, 16'h4000, 2'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL ovf_wrap: got %h want %h", got, {1'b1, 16'h4000, 2'd0, 1'b0, 1'b1});
    end
    bus2.m_ready = 1'b1;
    @(negedge clk);
    bus2.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus2.s_valid  = 1'b1;
      bus2.s_data   = d4[i];
      bus2.s_last   = (i == 3);
      bus2.find_min = 1'b0;
      checks++;
      if (bus2.s_ready !== 1'b1) begin errors++; $display("FAIL full_ready%0d: got %b want 1", i, bus2.s_ready); end
      @(negedge clk);
    end
    bus2.s_valid = 1'b0;
    got = {bus2.m_valid, bus2.m_value, bus2.m_index, bus2.m_nan, bus2.m_overflow};
    checks++;
    if (got !== {1'b1, 16'h4000, 2'd3, 1'b0, 1'b0}) begin
      errors++; $display("FAIL ovf_full_no_wrap: got %h want %h", got, {1'b1, 16'h4000, 2'd3, 1'b0, 1'b0});
    end
    bus2.m_ready = 1'b1;
    @(negedge clk);
    bus2.m_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [26:0] got;
    send_beat(16'h3C00, 1'b0, 1'b0);
    send_beat(16'h5000, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if ((bus.s_ready !== 1'b0) || (bus.m_valid !== 1'b0)) begin
      errors++; $display("FAIL rst_mid: s_ready %b m_valid %b want 0 0", bus.s_ready, bus.m_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_out: got %b want 0", bus.m_valid); end
    send_beat(16'h3800, 1'b0, 1'b0);
    send_beat(16'h3400, 1'b1, 1'b0);
    got = {bus.m_valid, bus.m_value, bus.m_index, bus.m_nan, bus.m_overflow};
    checks++;
    if (got !== {1'b1, 16'h3800, 8'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rst_then_packet: got %h want %h", got, {1'b1, 16'h3800, 8'd0, 1'b0, 1'b0});
    end
    // reset while a result waits: result dropped
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_out_drop: got %b want 0", bus.m_valid); end
    @(negedge clk);
  endtask

  initial begin
    bus.s_valid   = 1'b0;
    bus.s_data    = 16'h0000;
    bus.s_last    = 1'b0;
    bus.find_min  = 1'b0;
    bus.m_ready   = 1'b0;
    bus2.s_valid  = 1'b0;
    bus2.s_data   = 16'h0000;
    bus2.s_last   = 1'b0;
    bus2.find_min = 1'b0;
    bus2.m_ready  = 1'b0;
    test_reset();
    test_max();
    test_min();
    test_ties();
    test_nan();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
